// File: rtl/user_mbox_obi.sv
// user_mbox_obi: OBI subordinate for the user-domain slot (base 0x2000_1000,
// 4 KiB window). It is a word-wide software mailbox FIFO with push/pop
// registers, status, control and a level-threshold interrupt.
//
// Optional build macro: USER_MBOX_STATS_EN adds a STATS register at 0x010
// (saturating push/pop counters). Without it, 0x010 decodes as unmapped.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   obi_req_i  subordinate request  (a.addr, a.we, a.be, a.wdata, a.aid, req)
//   obi_rsp_o  subordinate response (gnt, rvalid, r.rdata, r.rid, r.err)
//   irq_o      level interrupt: irq_en && threshold != 0 && count >= threshold
//
// Register map (word offset = addr[11:2]):
//   0x000 TXDATA  W: push (be ignored)       R: 0
//   0x004 RXDATA  R: pop head (be ignored)   W: err
//   0x008 STATUS  R: [0] empty [1] full [2] overflow [15:8] count
//                 W: 1 to bit 2 clears overflow
//   0x00C CTRL    [0] irq_en, [1] flush (write-only), [15:8] threshold
//   0x010 STATS   (optional) R: [15:0] pushes [31:16] pops, W: clear

package user_mbox_obi_pkg;
    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam int unsigned IdWidth = 4;
    localparam obi_cfg_t ObiDefaultCfg = '{AddrWidth: 32, DataWidth: 32, IdWidth: IdWidth};

    typedef struct packed {
        logic [31:0]        addr;
        logic               we;
        logic [3:0]         be;
        logic [31:0]        wdata;
        logic [IdWidth-1:0] aid;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
    } obi_req_t;

    typedef struct packed {
        logic [31:0]        rdata;
        logic [IdWidth-1:0] rid;
        logic               err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;
endpackage

module user_mbox_obi #(
    parameter user_mbox_obi_pkg::obi_cfg_t ObiCfg = user_mbox_obi_pkg::ObiDefaultCfg,
    parameter type obi_req_t = user_mbox_obi_pkg::obi_req_t,
    parameter type obi_rsp_t = user_mbox_obi_pkg::obi_rsp_t,
    parameter int unsigned Depth = 8
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o,
    output logic     irq_o
);
    localparam int unsigned DW = ObiCfg.DataWidth;
    localparam int unsigned IW = ObiCfg.IdWidth;
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned PW = AW + 1;  // one extra bit distinguishes full from empty
    typedef logic [PW-1:0] ptr_t;

    ptr_t          wptr_q, rptr_q, wptr_d, rptr_d;
    logic [DW-1:0] mem_q [Depth];
    logic          ovf_q, ovf_d;
    logic          irq_en_q, irq_en_d;
    logic [7:0]    thr_q, thr_d;
    logic          rvalid_q, err_q, err_d, irq_q, irq_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [IW-1:0] rid_q;
    logic          push, pop;

    ptr_t       count, count_d;
    logic [7:0] count8;
    logic       empty, full;
    logic [9:0] off;

    assign count  = wptr_q - rptr_q;
    assign count8 = 8'(count);
    assign empty  = (count == '0);
    assign full   = (count == ptr_t'(Depth));
    assign off    = obi_req_i.a.addr[11:2];

`ifdef USER_MBOX_STATS_EN
    logic [15:0] push_cnt_q, push_cnt_d, pop_cnt_q, pop_cnt_d;
    logic        stats_clr;
`endif

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;
        thr_d    = thr_q;
        push     = 1'b0;
        pop      = 1'b0;
        rdata_d  = '0;
        err_d    = 1'b0;
`ifdef USER_MBOX_STATS_EN
        stats_clr = 1'b0;
`endif
        if (obi_req_i.req) begin
            unique case (off)
                10'h000: begin
                    if (obi_req_i.a.we) begin
                        if (full) begin
                            err_d = 1'b1;
                            ovf_d = 1'b1;
                        end else begin
                            push   = 1'b1;
                            wptr_d = wptr_q + ptr_t'(1);
                        end
                    end
                end
                10'h001: begin
                    if (obi_req_i.a.we || empty) begin
                        err_d = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        rdata_d = mem_q[rptr_q[AW-1:0]];
                        rptr_d  = rptr_q + ptr_t'(1);
                    end
                end
                10'h002: begin
                    if (obi_req_i.a.we) begin
                        if (obi_req_i.a.be[0] && obi_req_i.a.wdata[2]) ovf_d = 1'b0;
                    end else begin
                        rdata_d[15:0] = {count8, 5'h0, ovf_q, full, empty};
                    end
                end
                10'h003: begin
                    if (obi_req_i.a.we) begin
                        if (obi_req_i.a.be[0]) begin
                            irq_en_d = obi_req_i.a.wdata[0];
                            // flush: drop everything that is currently queued
                            if (obi_req_i.a.wdata[1]) rptr_d = wptr_q;
                        end
                        if (obi_req_i.a.be[1]) thr_d = obi_req_i.a.wdata[15:8];
                    end else begin
                        rdata_d[15:0] = {thr_q, 7'h0, irq_en_q};
                    end
                end
`ifdef USER_MBOX_STATS_EN
                10'h004: begin
                    if (obi_req_i.a.we) stats_clr = 1'b1;
                    else                rdata_d   = {pop_cnt_q, push_cnt_q};
                end
`endif
                default: err_d = 1'b1;
            endcase
        end

        // interrupt is evaluated on the state that exists after this edge
        count_d = wptr_d - rptr_d;
        irq_d   = irq_en_d && (thr_d != 8'h0) && (16'(count_d) >= {8'h0, thr_d});
    end

`ifdef USER_MBOX_STATS_EN
    always_comb begin
        push_cnt_d = push_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        if (stats_clr) begin
            push_cnt_d = '0;
            pop_cnt_d  = '0;
        end else begin
            if (push && push_cnt_q != 16'hFFFF) push_cnt_d = push_cnt_q + 16'd1;
            if (pop  && pop_cnt_q  != 16'hFFFF) pop_cnt_d  = pop_cnt_q  + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
        end else begin
            push_cnt_q <= push_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            thr_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            thr_q    <= thr_d;
            rvalid_q <= obi_req_i.req;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rid_q    <= obi_req_i.req ? obi_req_i.a.aid : '0;
            irq_q    <= irq_d;
        end
    end

    // storage needs no reset: the pointers define what is valid
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= obi_req_i.a.wdata;
    end

    always_comb begin
        obi_rsp_o          = '0;
        obi_rsp_o.gnt      = obi_req_i.req;
        obi_rsp_o.rvalid   = rvalid_q;
        obi_rsp_o.r.rdata  = rdata_q;
        obi_rsp_o.r.rid    = rid_q;
        obi_rsp_o.r.err    = err_q;
    end

    assign irq_o = irq_q;

`ifdef USER_MBOX_STATS_EN
    logic unused_ok;
    assign unused_ok = ^{obi_req_i.a.addr[31:12], obi_req_i.a.addr[1:0], obi_req_i.a.be[3:2]};
`else
    logic unused_ok;
    assign unused_ok = ^{obi_req_i.a.addr[31:12], obi_req_i.a.addr[1:0], obi_req_i.a.be[3:2], pop};
`endif
endmodule

// File: tb/tb_user_mbox_obi.sv
module tb_user_mbox_obi;
    import user_mbox_obi_pkg::*;

    localparam logic [11:0] TX = 12'h000, RX = 12'h004, ST = 12'h008, CT = 12'h00C;
    localparam logic [11:0] SS = 12'h010, BAD = 12'h020;

    logic     clk = 1'b0;
    logic     rst_n;
    obi_req_t req;
    obi_rsp_t rsp;
    logic     irq;

    always #5 clk = ~clk;

    user_mbox_obi #(.Depth(8)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .obi_req_i (req),
        .obi_rsp_o (rsp),
        .irq_o     (irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        err;
        logic        irq;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic we, input logic [11:0] a, input logic [31:0] wd,
                                input logic [3:0] be, input logic [31:0] rd, input logic e,
                                input logic q);
        vec_t v;
        v.we = we; v.addr = a; v.wdata = wd; v.be = be;
        v.rdata = rd; v.err = e; v.irq = q;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic we, input logic [11:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic [3:0] aid);
        req.req     = 1'b1;
        req.a.addr  = {20'h20001, a};
        req.a.we    = we;
        req.a.be    = be;
        req.a.wdata = wd;
        req.a.aid   = aid;
    endtask

    task automatic idle();
        req = '0;
    endtask

    // one transaction; starts and ends at a negedge
    task automatic apply(input vec_t v, input int idx);
        logic [3:0] aid;
        aid = 4'(idx + 3);
        drive(v.we, v.addr, v.wdata, v.be, aid);
        #1 chk($sformatf("v%0d gnt", idx), 32'(rsp.gnt), 32'd1);
        @(posedge clk);
        #1 idle();
        @(negedge clk);
        chk($sformatf("v%0d rvalid", idx), 32'(rsp.rvalid), 32'd1);
        chk($sformatf("v%0d rid", idx), 32'(rsp.r.rid), 32'(aid));
        chk($sformatf("v%0d rdata", idx), rsp.r.rdata, v.rdata);
        chk($sformatf("v%0d err", idx), 32'(rsp.r.err), 32'(v.err));
        chk($sformatf("v%0d irq", idx), 32'(irq), 32'(v.irq));
    endtask

    initial begin
        // ---- vector table ----
        add(0, ST, 0, 4'hF, 32'h0000_0001, 0, 0);
        add(1, TX, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        add(1, TX, 32'h1234_5678, 4'hF, 0, 0, 0);
        add(0, ST, 0, 4'hF, 32'h0000_0200, 0, 0);
        add(0, RX, 0, 4'hF, 32'hDEAD_BEEF, 0, 0);
        add(0, RX, 0, 4'hF, 32'h1234_5678, 0, 0);
        add(0, ST, 0, 4'hF, 32'h0000_0001, 0, 0);
        // fill past full; be is ignored for pushes
        for (int i = 0; i < 9; i++) add(1, TX, 32'h100 + 32'(i), 4'b0001, 0, i == 8, 0);
        add(0, ST, 0, 4'hF, 32'h0000_0806, 0, 0);
        add(1, ST, 32'h4, 4'hF, 0, 0, 0);
        add(0, ST, 0, 4'hF, 32'h0000_0802, 0, 0);
        add(0, RX, 0, 4'b0001, 32'h0000_0100, 0, 0);
        add(0, ST, 0, 4'hF, 32'h0000_0700, 0, 0);
        add(1, CT, 32'h2, 4'hF, 0, 0, 0);
        add(0, ST, 0, 4'hF, 32'h0000_0001, 0, 0);
        add(0, RX, 0, 4'hF, 0, 1, 0);
        add(1, RX, 32'h5, 4'hF, 0, 1, 0);
        add(0, BAD, 0, 4'hF, 0, 1, 0);
        add(1, BAD, 32'h7, 4'hF, 0, 1, 0);
        add(0, CT, 0, 4'hF, 0, 0, 0);
        // threshold interrupt
        add(1, CT, 32'h0000_0301, 4'hF, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, TX, 32'hC0DE_0000 + 32'(i), 4'hF, 0, 0, i == 2);
        add(0, CT, 0, 4'hF, 32'h0000_0301, 0, 1);
        add(0, RX, 0, 4'hF, 32'hC0DE_0000, 0, 0);
        add(1, CT, 32'h0000_0302, 4'hF, 0, 0, 0);
        add(0, ST, 0, 4'hF, 32'h0000_0001, 0, 0);
        add(0, CT, 0, 4'hF, 32'h0000_0300, 0, 0);
        // byte-enables on CTRL: byte0 only keeps threshold
        add(1, CT, 32'hFFFF_0001, 4'b0001, 0, 0, 0);
        add(0, CT, 0, 4'hF, 32'h0000_0301, 0, 0);
        // threshold beyond depth never fires
        add(1, CT, 32'h0000_0901, 4'hF, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, TX, 32'h200 + 32'(i), 4'hF, 0, 0, 0);
        add(0, ST, 0, 4'hF, 32'h0000_0802, 0, 0);
        // lowering threshold to Depth via byte1 alone fires on a full FIFO
        add(1, CT, 32'h0000_0800, 4'b0010, 0, 0, 1);
        add(1, CT, 32'h0000_0002, 4'b0001, 0, 0, 0);
        add(0, ST, 0, 4'hF, 32'h0000_0001, 0, 0);
        add(0, CT, 0, 4'hF, 32'h0000_0800, 0, 0);
        // threshold zero never fires
        add(1, CT, 32'h0000_0001, 4'hF, 0, 0, 0);
        add(1, TX, 32'h1, 4'hF, 0, 0, 0);
        add(1, CT, 32'h0000_0002, 4'hF, 0, 0, 0);
`ifdef USER_MBOX_STATS_EN
        add(1, SS, 0, 4'hF, 0, 0, 0);
        add(0, RX, 0, 4'hF, 0, 1, 0);
        for (int i = 0; i < 5; i++) add(1, TX, 32'h300 + 32'(i), 4'hF, 0, 0, 0);
        add(0, RX, 0, 4'hF, 32'h300, 0, 0);
        add(0, RX, 0, 4'hF, 32'h301, 0, 0);
        add(0, SS, 0, 4'hF, 32'h0002_0005, 0, 0);
        add(1, SS, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        add(0, SS, 0, 4'hF, 0, 0, 0);
        add(1, CT, 32'h0000_0002, 4'hF, 0, 0, 0);
`else
        add(0, SS, 0, 4'hF, 0, 1, 0);
        add(1, SS, 32'h1, 4'hF, 0, 1, 0);
`endif

        // ---- reset ----
        req   = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset rvalid", 32'(rsp.rvalid), 0);
        chk("reset rdata", rsp.r.rdata, 0);
        chk("reset rid/err", {27'h0, rsp.r.rid, rsp.r.err}, 0);
        chk("reset gnt", 32'(rsp.gnt), 0);
        chk("reset irq", 32'(irq), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle rvalid", 32'(rsp.rvalid), 0);

        // ---- table ----
        foreach (vecs[i]) apply(vecs[i], i);

        // ---- back-to-back: push, STATUS, pop in consecutive cycles ----
        drive(1, TX, 32'h0000_00AA, 4'hF, 4'd1);
        @(posedge clk); #1 drive(0, ST, 0, 4'hF, 4'd2);
        @(negedge clk);
        chk("b2b0 rvalid", 32'(rsp.rvalid), 1);
        chk("b2b0 rid", 32'(rsp.r.rid), 1);
        chk("b2b0 err", 32'(rsp.r.err), 0);
        @(posedge clk); #1 drive(0, RX, 0, 4'hF, 4'd3);
        @(negedge clk);
        chk("b2b1 rvalid", 32'(rsp.rvalid), 1);
        chk("b2b1 rid", 32'(rsp.r.rid), 2);
        chk("b2b1 status", rsp.r.rdata, 32'h0000_0100);
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("b2b2 rvalid", 32'(rsp.rvalid), 1);
        chk("b2b2 rid", 32'(rsp.r.rid), 3);
        chk("b2b2 pop", rsp.r.rdata, 32'h0000_00AA);
        @(negedge clk);
        chk("b2b idle rvalid", 32'(rsp.rvalid), 0);

        // ---- reset while a response is pending ----
        drive(1, TX, 32'h55, 4'hF, 4'd9);
        @(posedge clk); #1 idle();
        #1 rst_n = 1'b0;
        #1 chk("midrst rvalid", 32'(rsp.rvalid), 0);
        chk("midrst rid", 32'(rsp.r.rid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        begin
            vec_t v;
            v.we = 0; v.addr = ST; v.wdata = 0; v.be = 4'hF;
            v.rdata = 32'h0000_0001; v.err = 0; v.irq = 0;
            apply(v, 999);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
